// File: rtl/palette_sched_pkg.sv
// Shared types and constants for the sprite palette scheduler.
// The palette itself lives outside the scheduler so each sprite sheet can swap it.
package palette_sched_pkg;

   localparam int IDX_W          = 4;
   localparam int RGB_W          = 4;
   localparam int DEF_TRANSP_IDX = 0;
   localparam int DEF_BG_IDX     = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      LOOKUP = 2'd2
   } state_t;

   typedef struct packed {
      logic [RGB_W-1:0] red;
      logic [RGB_W-1:0] green;
      logic [RGB_W-1:0] blue;
   } rgb444_t;

endpackage

// File: rtl/sprite_palette_scheduler.sv
// Per-pixel layer compositor: snapshots NUM_REQ layer indices on a strobe, scans one per clock, looks up the winner.
// Colour is valid p+2 clocks after the strobe (winner p) and NUM_REQ+1 for background; a strobe mid-scan restarts and sets overrun.
module sprite_palette_scheduler #(
   parameter int               NUM_REQ    = 4,
   parameter int               IDX_W      = palette_sched_pkg::IDX_W,
   parameter logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(palette_sched_pkg::DEF_TRANSP_IDX),
   parameter logic [IDX_W-1:0] BG_IDX     = IDX_W'(palette_sched_pkg::DEF_BG_IDX),
   localparam int              SEL_W      = $clog2(NUM_REQ + 1),
   localparam int              PTR_W      = $clog2(NUM_REQ),
   localparam int              RGB_W      = palette_sched_pkg::RGB_W
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_pixel_strobe,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ*IDX_W-1:0] i_req_index,
   input  logic                     i_clr_overrun,
   output logic [IDX_W-1:0]         o_pal_index,
   input  logic [RGB_W-1:0]         i_pal_red,
   input  logic [RGB_W-1:0]         i_pal_green,
   input  logic [RGB_W-1:0]         i_pal_blue,
   output logic [RGB_W-1:0]         o_red,
   output logic [RGB_W-1:0]         o_green,
   output logic [RGB_W-1:0]         o_blue,
   output logic                     o_out_valid,
   output logic [SEL_W-1:0]         o_layer_sel,
   output logic                     o_busy,
   output logic                     o_overrun
);
   import palette_sched_pkg::*;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [PTR_W-1:0]         r_ptr;
   logic [PTR_W-1:0]         w_ptr_nxt;
   logic [NUM_REQ-1:0]       r_snap_vld;
   logic [NUM_REQ*IDX_W-1:0] r_snap_idx;
   logic [IDX_W-1:0]         r_pal_index;
   logic [SEL_W-1:0]         r_layer_sel;
   rgb444_t                  r_rgb;
   logic                     r_out_valid;
   logic                     r_overrun;

   logic [IDX_W-1:0]         w_cur_idx;
   logic                     w_cur_opaque;
   logic                     w_snap_ld;
   logic                     w_win;
   logic                     w_bg;
   logic                     w_rgb_ld;
   logic                     w_ovr_set;

   assign w_cur_idx    = r_snap_idx[r_ptr*IDX_W +: IDX_W];
   assign w_cur_opaque = r_snap_vld[r_ptr] && (w_cur_idx != TRANSP_IDX);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_snap_ld   = 1'b0;
      w_win       = 1'b0;
      w_bg        = 1'b0;
      w_rgb_ld    = 1'b0;
      w_ovr_set   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_pixel_strobe) begin
               w_snap_ld   = 1'b1;
               w_ptr_nxt   = '0;
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            // A strobe here abandons the slot before it can touch any output.
            if (i_pixel_strobe) begin
               w_ovr_set = 1'b1;
               w_snap_ld = 1'b1;
               w_ptr_nxt = '0;
            end else if (w_cur_opaque) begin
               w_win       = 1'b1;
               w_state_nxt = LOOKUP;
            end else if (r_ptr == PTR_W'(NUM_REQ - 1)) begin
               w_bg        = 1'b1;
               w_state_nxt = LOOKUP;
            end else begin
               w_ptr_nxt = r_ptr + PTR_W'(1);
            end
         end
         LOOKUP: begin
            w_rgb_ld = 1'b1;
            if (i_pixel_strobe) begin
               w_snap_ld   = 1'b1;
               w_ptr_nxt   = '0;
               w_state_nxt = SCAN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_snap_vld  <= '0;
         r_snap_idx  <= '0;
         r_pal_index <= '0;
         r_layer_sel <= '0;
         r_rgb       <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_out_valid <= w_rgb_ld;
         if (w_snap_ld) begin
            r_snap_vld <= i_req_valid;
            r_snap_idx <= i_req_index;
         end
         if (w_win) begin
            r_pal_index <= w_cur_idx;
            r_layer_sel <= SEL_W'(r_ptr);
         end else if (w_bg) begin
            r_pal_index <= BG_IDX;
            r_layer_sel <= SEL_W'(NUM_REQ);
         end
         if (w_rgb_ld) begin
            r_rgb <= '{red: i_pal_red, green: i_pal_green, blue: i_pal_blue};
         end
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_pal_index = r_pal_index;
   assign o_red       = r_rgb.red;
   assign o_green     = r_rgb.green;
   assign o_blue      = r_rgb.blue;
   assign o_out_valid = r_out_valid;
   assign o_layer_sel = r_layer_sel;
   assign o_busy      = (r_state != IDLE);
   assign o_overrun   = r_overrun;

endmodule
